// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: requester indices, owner vector and burst state shared by the arbiter files
package mem_arbiter_pkg;
  localparam int ARB_MEM = 0;
  localparam int ARB_IF = 1;
  localparam int ARB_CP = 2;
  typedef logic [2:0] arb_owner_t;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;
  function automatic arb_owner_t onehot(input int idx);
    return arb_owner_t'(1) << idx;
  endfunction
endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// arb_prio_sel: fixed-priority one-hot grant; CP2 overrides when locked in a burst or starved
module arb_prio_sel
  import mem_arbiter_pkg::*;
(
  input  logic       [2:0] req,
  input  logic             lock_win,
  input  logic             starve_win,
  output arb_owner_t       gnt
);
  always_comb begin
    gnt = (lock_win | starve_win) ? onehot(ARB_CP) :
          req[ARB_MEM]            ? onehot(ARB_MEM) :
          req[ARB_IF]             ? onehot(ARB_IF) :
          req[ARB_CP]             ? onehot(ARB_CP) : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between MEM, IF and CP2 with starvation promotion,
// locked CP2 bursts and one-cycle read data return
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              i_req,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [3:0]        m_wea,
  input  logic [3:0]        c_wea,
  input  logic              c_lock,
  output logic              m_gnt,
  output logic              i_gnt,
  output logic              c_gnt,
  output logic              m_rvalid,
  output logic              i_rvalid,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              m_busy,
  output logic              i_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wea,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d, burst_inc;
  logic cool_q, cool_d;
  arb_owner_t rd_owner_q, rd_owner_d, sel_gnt, gnt;
  logic cp_ok, lock_win, starve_win;
  assign cp_ok = c_req & ~cool_q;
  assign lock_win = (state_q == ARB_BURST) & cp_ok & c_lock;
  assign starve_win = (starve_cnt_q == SW'(STARVE_LIMIT)) & cp_ok;
  arb_prio_sel u_sel (
    .req        ({cp_ok, i_req, m_req}),
    .lock_win   (lock_win),
    .starve_win (starve_win),
    .gnt        (sel_gnt)
  );
  always_comb begin
    gnt = rst ? '0 : sel_gnt;
    m_gnt = gnt[ARB_MEM];
    i_gnt = gnt[ARB_IF];
    c_gnt = gnt[ARB_CP];
    m_busy = m_req & ~m_gnt & ~rst;
    i_busy = i_req & ~i_gnt & ~rst;
    mem_en = |gnt;
    mem_addr = m_gnt ? m_addr : i_gnt ? i_addr : c_gnt ? c_addr : '0;
    mem_wdata = m_gnt ? m_wdata : c_gnt ? c_wdata : '0;
    mem_wea = m_gnt ? m_wea : c_gnt ? c_wea : 4'h0;
    rd_owner_d = gnt & {~|c_wea, 1'b1, ~|m_wea};
    {c_rvalid, i_rvalid, m_rvalid} = rd_owner_q;
    rdata = |rd_owner_q ? mem_rdata : '0;
    starve_cnt_d = (c_gnt | ~c_req) ? '0 :
                   (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q : starve_cnt_q + SW'(1);
    // entry counts as the first grant; reaching the cap ends the burst and blocks CP2 once
    burst_inc = (state_q == ARB_IDLE) ? BW'(1) : burst_cnt_q + BW'(1);
    cool_d = c_gnt & c_lock & (burst_inc == BW'(BURST_MAX));
    state_d = (c_gnt & c_lock & ~cool_d) ? ARB_BURST : ARB_IDLE;
    burst_cnt_d = (state_d == ARB_BURST) ? burst_inc : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      starve_cnt_q <= '0;
      burst_cnt_q <= '0;
      cool_q <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cool_q <= cool_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule
